// File: rtl/fifo36_to_ll8.sv
// fifo36_to_ll8
// Unpacks 36-bit short-FIFO lines into a byte-wide LocalLink-style stream
// for the GEMAC TX path. One line is held at a time. Its bytes are sent one
// per cycle, and any unused bytes of a partial EOF word are skipped. Lines
// that arrive outside a frame are swallowed and flagged on err.
//
// Ports:
//   clock       single rising-edge clock
//   reset       synchronous active-high reset
//   clear       synchronous active-high clear, same effect as reset
//   datain      [31:0] data, [32] SOF, [33] EOF, [35:34] occupancy
//               (0 = 4 bytes valid, 1..3 = that many bytes, only meaningful with EOF)
//   src_rdy_i   upstream line valid
//   dst_rdy_o   this block accepts a line this cycle
//   ll_data     output byte
//   ll_sof      first byte of frame
//   ll_eof      last byte of frame
//   ll_src_rdy  ll_data valid
//   ll_dst_rdy  downstream accepts the byte
//   err         one-cycle pulse after a line that breaks framing
//
// Parameter BIG_ENDIAN: 1 sends datain[31:24] first, 0 sends datain[7:0] first.

module fifo36_to_ll8 #(
    parameter int BIG_ENDIAN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [35:0] datain,
    input  logic        src_rdy_i,
    output logic        dst_rdy_o,
    output logic [7:0]  ll_data,
    output logic        ll_sof,
    output logic        ll_eof,
    output logic        ll_src_rdy,
    input  logic        ll_dst_rdy,
    output logic        err
);

    typedef enum logic {
        IDLE,
        INFRAME
    } state_t;

    state_t      state;
    state_t      state_next;
    state_t      frame_state;
    logic [35:0] hold;
    logic [35:0] hold_next;
    logic        valid;
    logic        valid_next;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic        err_next;

    logic        held_sof;
    logic        held_eof;
    logic [1:0]  held_occ;
    logic [1:0]  last_idx;
    logic        at_last;
    logic        byte_xfer;
    logic        line_xfer;
    logic        in_sof;
    logic        in_eof;

    assign held_sof = hold[32];
    assign held_eof = hold[33];
    assign held_occ = hold[35:34];
    assign in_sof   = datain[32];
    assign in_eof   = datain[33];

    // A non-zero occupancy trims the EOF word. Otherwise all four bytes go out.
    assign last_idx = (held_eof && (held_occ != 2'd0)) ? (held_occ - 2'd1) : 2'd3;
    assign at_last  = (idx == last_idx);

    // Lines outside a frame are never loaded, so a valid held word is always
    // part of a frame.
    assign ll_src_rdy = valid;
    assign byte_xfer  = ll_src_rdy & ll_dst_rdy;

    // ll_dst_rdy feeds dst_rdy_o combinationally. This lets the next line load
    // on the same edge that sends the last byte, so no bubble appears between
    // words.
    assign dst_rdy_o = ~valid | (byte_xfer & at_last);
    assign line_xfer = src_rdy_i & dst_rdy_o;

    assign ll_sof = held_sof & (idx == 2'd0);
    assign ll_eof = held_eof & at_last;

    // The frame ends on the same edge as its EOF byte. A line accepted on that
    // edge must be judged against IDLE, or a back-to-back SOF would be flagged.
    assign frame_state = (byte_xfer && at_last && held_eof) ? IDLE : state;

    // Byte lane select for the current index.
    always_comb begin
        ll_data = 8'h00;
        if (BIG_ENDIAN != 0) begin
            case (idx)
                2'd0:    ll_data = hold[31:24];
                2'd1:    ll_data = hold[23:16];
                2'd2:    ll_data = hold[15:8];
                default: ll_data = hold[7:0];
            endcase
        end else begin
            case (idx)
                2'd0:    ll_data = hold[7:0];
                2'd1:    ll_data = hold[15:8];
                2'd2:    ll_data = hold[23:16];
                default: ll_data = hold[31:24];
            endcase
        end
    end

    // Next-state logic. Byte advance is handled first. A line accepted on the
    // same edge then overrides valid/idx. That is what keeps the stream
    // gapless when the last byte and the next line cross.
    always_comb begin
        state_next = state;
        hold_next  = hold;
        valid_next = valid;
        idx_next   = idx;
        err_next   = 1'b0;

        if (byte_xfer) begin
            if (at_last) begin
                valid_next = 1'b0;
                if (held_eof) begin
                    state_next = IDLE;
                end
            end else begin
                idx_next = idx + 2'd1;
            end
        end

        if (line_xfer) begin
            if ((frame_state == IDLE) && !in_sof) begin
                // Orphan line: it is accepted so upstream does not stall,
                // but it is dropped.
                err_next = 1'b1;
            end else begin
                // A SOF inside a frame abandons the old frame and starts a
                // new one.
                err_next   = (frame_state == INFRAME) && in_sof;
                hold_next  = datain;
                valid_next = 1'b1;
                idx_next   = 2'd0;
                state_next = (in_sof && in_eof) ? IDLE : INFRAME;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state <= IDLE;
            hold  <= 36'd0;
            valid <= 1'b0;
            idx   <= 2'd0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
            valid <= valid_next;
            idx   <= idx_next;
            err   <= err_next;
        end
    end

endmodule

// File: tb/tb_fifo36_to_ll8.sv
// tb_fifo36_to_ll8
// Drives a big-endian and a little-endian instance from the same stimulus.
// Hand-computed byte sequences go into per-instance queues. A monitor pops
// and compares on every byte transfer, checks that outputs hold while
// stalled, and counts err pulses.

module tb_fifo36_to_ll8;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic [35:0] datain;
    logic        src_rdy_i;
    logic        ll_dst_rdy;

    logic        dst_rdy_be, ll_sof_be, ll_eof_be, ll_src_rdy_be, err_be;
    logic [7:0]  ll_data_be;
    logic        dst_rdy_le, ll_sof_le, ll_eof_le, ll_src_rdy_le, err_le;
    logic [7:0]  ll_data_le;

    exp_t sb_be[$];
    exp_t sb_le[$];

    int vectors     = 0;
    int miscompares = 0;
    int exp_err     = 0;
    int obs_err_be  = 0;
    int obs_err_le  = 0;
    bit model_inframe = 1'b0;
    int bp_mode     = 0;

    always #5 clock = ~clock;

    fifo36_to_ll8 #(.BIG_ENDIAN(1)) dut_be (
        .clock(clock), .reset(reset), .clear(clear),
        .datain(datain), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_be),
        .ll_data(ll_data_be), .ll_sof(ll_sof_be), .ll_eof(ll_eof_be),
        .ll_src_rdy(ll_src_rdy_be), .ll_dst_rdy(ll_dst_rdy), .err(err_be)
    );

    fifo36_to_ll8 #(.BIG_ENDIAN(0)) dut_le (
        .clock(clock), .reset(reset), .clear(clear),
        .datain(datain), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_le),
        .ll_data(ll_data_le), .ll_sof(ll_sof_le), .ll_eof(ll_eof_le),
        .ll_src_rdy(ll_src_rdy_le), .ll_dst_rdy(ll_dst_rdy), .err(err_le)
    );

    function automatic logic [35:0] mk(input logic sof, input logic eof,
                                       input logic [1:0] occ, input logic [31:0] d);
        return {occ, eof, sof, d};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic compareByte(input string tag, input bit have, input exp_t e,
                               input logic [7:0] d, input logic s, input logic f);
        vectors++;
        if (!have) begin
            miscompares++;
            $display("[TB] FAIL %s: unexpected byte %h sof=%b eof=%b, expected none", tag, d, s, f);
        end else if ({d, s, f} !== {e.data, e.sof, e.eof}) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h sof=%b eof=%b, expected %h sof=%b eof=%b",
                     tag, d, s, f, e.data, e.sof, e.eof);
        end
    endtask

    // Offers one line and waits for it to be taken. exp_* lists the bytes in
    // emission order, left-justified, for each instance.
    task automatic applyStimulus(input logic [35:0] line, input logic [31:0] exp_be,
                                 input logic [31:0] exp_le, input int n, output int waits);
        exp_t e;
        int   guard;
        @(negedge clock);
        datain    = line;
        src_rdy_i = 1'b1;
        #1;
        guard = 0;
        while (!(dst_rdy_be && dst_rdy_le) && guard < 100) begin
            @(negedge clock);
            #1;
            guard++;
        end
        waits = guard;
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL line accept timeout: got dst_rdy_o=%b/%b, expected 1", dst_rdy_be, dst_rdy_le);
        end
        if (!model_inframe && !line[32]) begin
            exp_err++;
        end else begin
            if (model_inframe && line[32]) exp_err++;
            for (int i = 0; i < n; i++) begin
                e.sof  = line[32] && (i == 0);
                e.eof  = line[33] && (i == n - 1);
                e.data = exp_be[31 - 8*i -: 8];
                sb_be.push_back(e);
                e.data = exp_le[31 - 8*i -: 8];
                sb_le.push_back(e);
            end
            model_inframe = !line[33];
        end
    endtask

    task automatic idleLine();
        @(negedge clock);
        src_rdy_i = 1'b0;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((sb_be.size() != 0 || sb_le.size() != 0) && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 300) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain timeout: got %0d/%0d bytes pending, expected 0", sb_be.size(), sb_le.size());
        end
    endtask

    // Downstream ready: 0 = always ready, 1 = repeating 1,0,0, 2 = manual.
    initial begin
        int ph;
        ph = 0;
        ll_dst_rdy = 1'b1;
        forever begin
            @(negedge clock);
            if (bp_mode == 0) begin
                ll_dst_rdy = 1'b1;
            end else if (bp_mode == 1) begin
                ll_dst_rdy = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // The monitor samples mid-cycle, after the drivers settle. These are the
    // values the next rising edge will act on.
    initial begin
        exp_t       e;
        bit         have;
        bit         prev_stall_be, prev_stall_le, prev_clr;
        logic [9:0] prev_be, prev_le;
        prev_stall_be = 1'b0;
        prev_stall_le = 1'b0;
        prev_clr      = 1'b1;
        prev_be       = '0;
        prev_le       = '0;
        forever begin
            @(negedge clock);
            #2;
            if (err_be) obs_err_be++;
            if (err_le) obs_err_le++;
            if (prev_stall_be && !prev_clr)
                checkOutput("be stall hold", {21'd0, ll_src_rdy_be, ll_data_be, ll_sof_be, ll_eof_be},
                            {21'd0, 1'b1, prev_be});
            if (prev_stall_le && !prev_clr)
                checkOutput("le stall hold", {21'd0, ll_src_rdy_le, ll_data_le, ll_sof_le, ll_eof_le},
                            {21'd0, 1'b1, prev_le});
            if (ll_src_rdy_be && !ll_dst_rdy)
                checkOutput("be dst_rdy in stall", {31'd0, dst_rdy_be}, 32'd0);
            if (ll_src_rdy_be && ll_dst_rdy) begin
                have = (sb_be.size() != 0);
                e = have ? sb_be.pop_front() : '0;
                compareByte("be byte", have, e, ll_data_be, ll_sof_be, ll_eof_be);
            end
            if (ll_src_rdy_le && ll_dst_rdy) begin
                have = (sb_le.size() != 0);
                e = have ? sb_le.pop_front() : '0;
                compareByte("le byte", have, e, ll_data_le, ll_sof_le, ll_eof_le);
            end
            prev_stall_be = ll_src_rdy_be && !ll_dst_rdy;
            prev_stall_le = ll_src_rdy_le && !ll_dst_rdy;
            prev_be       = {ll_data_be, ll_sof_be, ll_eof_be};
            prev_le       = {ll_data_le, ll_sof_le, ll_eof_le};
            prev_clr      = reset || clear;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        reset     = 1'b1;
        clear     = 1'b0;
        datain    = '0;
        src_rdy_i = 1'b0;

        // Reset state after two edges: {dst_rdy, src_rdy, data, sof, eof, err}.
        repeat (2) @(negedge clock);
        #1;
        checkOutput("reset be", {19'd0, dst_rdy_be, ll_src_rdy_be, ll_data_be, ll_sof_be, ll_eof_be, err_be},
                    {19'd0, 13'b1_0_00000000_0_0_0});
        checkOutput("reset le", {19'd0, dst_rdy_le, ll_src_rdy_le, ll_data_le, ll_sof_le, ll_eof_le, err_le},
                    {19'd0, 13'b1_0_00000000_0_0_0});
        reset = 1'b0;

        $display("[TB] single-line frame DEADBEEF");
        applyStimulus(mk(1, 1, 2'd0, 32'hDEADBEEF), 32'hDEADBEEF, 32'hEFBEADDE, 4, w);
        idleLine();
        waitDrain();

        $display("[TB] orphan line in IDLE");
        applyStimulus(mk(0, 0, 2'd0, 32'h12345678), 32'h0, 32'h0, 0, w);
        idleLine();
        #1;
        checkOutput("orphan err", {30'd0, err_be, err_le}, 32'd3);
        checkOutput("orphan no output", {30'd0, ll_src_rdy_be, ll_src_rdy_le}, 32'd0);
        @(negedge clock);
        #1;
        checkOutput("orphan err one cycle", {30'd0, err_be, err_le}, 32'd0);

        $display("[TB] three-line frame ending occ=2");
        applyStimulus(mk(1, 0, 2'd0, 32'hA0A1A2A3), 32'hA0A1A2A3, 32'hA3A2A1A0, 4, w);
        applyStimulus(mk(0, 0, 2'd0, 32'hB0B1B2B3), 32'hB0B1B2B3, 32'hB3B2B1B0, 4, w);
        checkOutput("word2 accept waits", w, 32'd3);
        applyStimulus(mk(0, 1, 2'd2, 32'h11223344), 32'h11220000, 32'h44330000, 2, w);
        checkOutput("word3 accept waits", w, 32'd3);
        idleLine();
        waitDrain();

        $display("[TB] SOF inside a frame");
        applyStimulus(mk(1, 0, 2'd0, 32'h5A5B5C5D), 32'h5A5B5C5D, 32'h5D5C5B5A, 4, w);
        applyStimulus(mk(1, 1, 2'd1, 32'h77665544), 32'h77000000, 32'h44000000, 1, w);
        idleLine();
        #1;
        checkOutput("mid-frame sof err", {30'd0, err_be, err_le}, 32'd3);
        waitDrain();

        $display("[TB] backpressure 1,0,0");
        #1;
        bp_mode = 1;
        applyStimulus(mk(1, 0, 2'd0, 32'hC0C1C2C3), 32'hC0C1C2C3, 32'hC3C2C1C0, 4, w);
        applyStimulus(mk(0, 1, 2'd3, 32'hD0D1D2D3), 32'hD0D1D200, 32'hD3D2D100, 3, w);
        idleLine();
        waitDrain();
        #1;
        bp_mode = 2;
        ll_dst_rdy = 1'b0;

        $display("[TB] clear after byte 1");
        applyStimulus(mk(1, 0, 2'd0, 32'hE0E1E2E3), 32'hE0E1E2E3, 32'hE3E2E1E0, 4, w);
        @(negedge clock);
        src_rdy_i  = 1'b0;
        ll_dst_rdy = 1'b1;
        @(negedge clock);
        @(negedge clock);
        ll_dst_rdy = 1'b0;
        clear      = 1'b1;
        #3;
        checkOutput("bytes left before clear", sb_be.size(), 32'd2);
        sb_be.delete();
        sb_le.delete();
        model_inframe = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        #1;
        checkOutput("clear src_rdy", {30'd0, ll_src_rdy_be, ll_src_rdy_le}, 32'd0);
        checkOutput("clear dst_rdy", {30'd0, dst_rdy_be, dst_rdy_le}, 32'd3);
        bp_mode    = 0;
        ll_dst_rdy = 1'b1;

        $display("[TB] frame 04030201 after clear");
        applyStimulus(mk(1, 1, 2'd0, 32'h04030201), 32'h04030201, 32'h01020304, 4, w);
        idleLine();
        waitDrain();
        repeat (5) @(negedge clock);

        checkOutput("err pulses be", obs_err_be, 32'd2);
        checkOutput("err pulses le", obs_err_le, 32'd2);
        checkOutput("err model count", exp_err, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
